// File: rtl/data_memory_responder.sv
// Word-addressed data memory answering processor memory-stage read/write strobes.
// Fixed LATENCY cycles from acceptance to a one-cycle done pulse; strobes outside IDLE are dropped.
module data_memory_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mem_read_en,
  input  logic                  mem_write_en,
  input  logic [31:0]           address,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  done,
  output logic                  busy,
  output logic                  error
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  logic                  misaligned;
  logic                  out_of_range;
  logic                  go_resp;

  assign misaligned   = |address[1:0];
  assign out_of_range = |address[31:ADDR_WIDTH+2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    err_d   = err_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    go_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_read_en || mem_write_en) begin
          wr_d    = mem_write_en;
          err_d   = (mem_read_en && mem_write_en) || misaligned || out_of_range;
          idx_d   = address[ADDR_WIDTH+1:2];
          wdata_d = write_data;
          cnt_d   = CNT_W'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d = S_RESP;
            go_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= 1) begin
          state_d = S_RESP;
          go_resp = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The _d request fields are valid on the edge entering RESP, covering the LATENCY=1 bypass.
  always_comb begin
    rdata_d = rdata_q;
    if (go_resp && !wr_d && !err_d) begin
      rdata_d = mem[idx_d];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Array is never cleared; reset only suppresses an in-flight commit.
  always_ff @(posedge clock) begin
    if (!reset && go_resp && wr_d && !err_d) begin
      mem[idx_d] <= wdata_d;
    end
  end

  assign read_data = rdata_q;
  assign done      = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);
  assign error     = (state_q == S_RESP) && err_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: LATENCY=2 instance plus a LATENCY=1 instance.
module tb_data_memory_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        rd_a = 1'b0, wr_a = 1'b0;
  logic [31:0] addr_a = '0, wd_a = '0;
  logic [31:0] rdata_a;
  logic        done_a, busy_a, err_a;

  logic        rd_b = 1'b0, wr_b = 1'b0;
  logic [31:0] addr_b = '0, wd_b = '0;
  logic [31:0] rdata_b;
  logic        done_b, busy_b, err_b;

  int errors = 0;
  int checks = 0;
  int done_seen;

  always #5 clock = ~clock;

  data_memory_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .LATENCY(2)) dut_a (
    .clock(clock), .reset(reset), .mem_read_en(rd_a), .mem_write_en(wr_a),
    .address(addr_a), .write_data(wd_a), .read_data(rdata_a),
    .done(done_a), .busy(busy_a), .error(err_a)
  );

  data_memory_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .LATENCY(1)) dut_b (
    .clock(clock), .reset(reset), .mem_read_en(rd_b), .mem_write_en(wr_b),
    .address(addr_b), .write_data(wd_b), .read_data(rdata_b),
    .done(done_b), .busy(busy_b), .error(err_b)
  );

  // Called at a negedge with dut_a idle; returns at the negedge of the first cycle after acceptance.
  task automatic send_a(input logic rd, input logic wr, input logic [31:0] ad, input logic [31:0] d);
    rd_a = rd; wr_a = wr; addr_a = ad; wd_a = d;
    @(negedge clock);
    rd_a = 1'b0; wr_a = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (rdata_a !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h exp 00000000", rdata_a); end
    checks++; if (done_a !== 1'b0)   begin errors++; $display("FAIL reset_done: got %b exp 0", done_a); end
    checks++; if (busy_a !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b exp 0", busy_a); end
    checks++; if (err_a !== 1'b0)    begin errors++; $display("FAIL reset_error: got %b exp 0", err_a); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_write_read;
    send_a(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL wr_busy_t1: got %b exp 1", busy_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL wr_done_t1: got %b exp 0", done_a); end
    @(negedge clock);
    checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL wr_done_t2: got %b exp 1", done_a); end
    checks++; if (err_a !== 1'b0)  begin errors++; $display("FAIL wr_error_t2: got %b exp 0", err_a); end
    @(negedge clock);
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL wr_done_t3: got %b exp 0", done_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL wr_busy_t3: got %b exp 0", busy_a); end
    send_a(1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clock);
    checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL rd_done: got %b exp 1", done_a); end
    checks++; if (rdata_a !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h exp DEADBEEF", rdata_a); end
    repeat (2) @(negedge clock);
    checks++; if (rdata_a !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_hold: got %h exp DEADBEEF", rdata_a); end
  endtask

  task automatic test_misaligned;
    send_a(1'b0, 1'b1, 32'h13, 32'h11111111);
    @(negedge clock);
    checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL mis_wr_done: got %b exp 1", done_a); end
    checks++; if (err_a !== 1'b1)  begin errors++; $display("FAIL mis_wr_error: got %b exp 1", err_a); end
    @(negedge clock);
    checks++; if (err_a !== 1'b0)  begin errors++; $display("FAIL mis_err_drop: got %b exp 0", err_a); end
    send_a(1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clock);
    checks++; if (rdata_a !== 32'hDEADBEEF) begin errors++; $display("FAIL mis_mem4: got %h exp DEADBEEF", rdata_a); end
    @(negedge clock);
    send_a(1'b1, 1'b0, 32'h402, 32'h0);
    @(negedge clock);
    checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL oor_error: got %b exp 1", err_a); end
    checks++; if (rdata_a !== 32'hDEADBEEF) begin errors++; $display("FAIL oor_rdata: got %h exp DEADBEEF", rdata_a); end
    @(negedge clock);
  endtask

  task automatic test_both_strobes;
    send_a(1'b0, 1'b1, 32'h20, 32'hAAAA5555);
    repeat (2) @(negedge clock);
    send_a(1'b1, 1'b1, 32'h20, 32'h0BADF00D);
    @(negedge clock);
    checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL both_done: got %b exp 1", done_a); end
    checks++; if (err_a !== 1'b1)  begin errors++; $display("FAIL both_error: got %b exp 1", err_a); end
    @(negedge clock);
    send_a(1'b1, 1'b0, 32'h20, 32'h0);
    @(negedge clock);
    checks++; if (rdata_a !== 32'hAAAA5555) begin errors++; $display("FAIL both_mem8: got %h exp AAAA5555", rdata_a); end
    @(negedge clock);
  endtask

  task automatic test_strobe_while_busy;
    send_a(1'b0, 1'b1, 32'h30, 32'h00C0FFEE);
    wr_a = 1'b1; addr_a = 32'h30; wd_a = 32'h12345678;
    @(negedge clock);
    wr_a = 1'b0;
    checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL busy_done: got %b exp 1", done_a); end
    @(negedge clock);
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL busy_not_queued: got %b exp 0", busy_a); end
    send_a(1'b1, 1'b0, 32'h30, 32'h0);
    @(negedge clock);
    checks++; if (rdata_a !== 32'h00C0FFEE) begin errors++; $display("FAIL busy_mem12: got %h exp 00C0FFEE", rdata_a); end
    @(negedge clock);
  endtask

  task automatic test_reset_during_wait;
    send_a(1'b0, 1'b1, 32'h40, 32'h01020304);
    repeat (2) @(negedge clock);
    send_a(1'b0, 1'b1, 32'h40, 32'hCAFEBABE);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (done_a === 1'b1) done_seen++;
      @(negedge clock);
    end
    checks++; if (done_seen != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses exp 0", done_seen); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b exp 0", busy_a); end
    send_a(1'b1, 1'b0, 32'h40, 32'h0);
    @(negedge clock);
    checks++; if (rdata_a === 32'hCAFEBABE) begin errors++; $display("FAIL abort_committed: got %h exp not CAFEBABE", rdata_a); end
    checks++; if (rdata_a !== 32'h01020304) begin errors++; $display("FAIL abort_mem16: got %h exp 01020304", rdata_a); end
    @(negedge clock);
  endtask

  task automatic test_latency1;
    rd_b = 1'b0; wr_b = 1'b1; addr_b = 32'h8; wd_b = 32'h5A5A5A5A;
    @(negedge clock);
    wr_b = 1'b0;
    checks++; if (done_b !== 1'b1) begin errors++; $display("FAIL l1_wr_done: got %b exp 1", done_b); end
    checks++; if (err_b !== 1'b0)  begin errors++; $display("FAIL l1_wr_error: got %b exp 0", err_b); end
    @(negedge clock);
    checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL l1_idle: got %b exp 0", busy_b); end
    rd_b = 1'b1; addr_b = 32'h8;
    @(negedge clock);
    rd_b = 1'b0;
    checks++; if (done_b !== 1'b1) begin errors++; $display("FAIL l1_rd_done: got %b exp 1", done_b); end
    checks++; if (rdata_b !== 32'h5A5A5A5A) begin errors++; $display("FAIL l1_rd_data: got %h exp 5A5A5A5A", rdata_b); end
    @(negedge clock);
    checks++; if (done_b !== 1'b0) begin errors++; $display("FAIL l1_done_drop: got %b exp 0", done_b); end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_write_read();
    test_misaligned();
    test_both_strobes();
    test_strobe_while_busy();
    test_reset_during_wait();
    test_latency1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
